r16_tf_mul_ctrl: RTL and testbench

// Sequencer for the radix-16 twiddle-factor multiply stage of the 65536-point NTT/FFT.

---
 rtl/r16_tf_pkg.sv | 9 +
 rtl/r16_ctrl_delay_line.sv | 28 ++
 rtl/r16_tf_mul_ctrl.sv | 85 ++++++++
 tb/tb_r16_tf_mul_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/r16_tf_pkg.sv
// r16_tf_pkg: shared state encoding and default sizing for the radix-16 twiddle multiply stage
package r16_tf_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} r16_state_e;
  localparam int R16_STAGE_NUM  = 4;
  localparam int R16_RADIX_LOG2 = 4;
  localparam int R16_GROUP_NUM  = 4096;
  localparam int R16_ADDR_W     = 12;
  localparam int R16_MUL_LAT    = 3;
endpackage

// File: rtl/r16_ctrl_delay_line.sv
// r16_ctrl_delay_line: fixed-latency shift register carrying {last,valid} beside the multiplier lanes
// Ports: clk, rst_n (sync active-low clear), din -> dout after DEPTH cycles,
//        valid_any = bit 0 set in any stage (pipeline not yet drained).
module r16_ctrl_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid_any
);
  logic [WIDTH-1:0] pipe [DEPTH];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign dout = pipe[DEPTH-1];
  always_comb begin
    valid_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) valid_any = valid_any | pipe[i][0];
  end
endmodule

// File: rtl/r16_tf_mul_ctrl.sv
// r16_tf_mul_ctrl: sequences one radix-16 twiddle-multiply stage pass and tracks the multiplier latency
// Ports: clk, rst_n (sync active-low), start/stage_sel (pass launch), in_valid/in_ready (group handshake),
//        tf_addr/tf_bypass (twiddle ROM request for the accepted group), out_valid/out_last (lane outputs),
//        busy, done (one-cycle drain pulse).
// Optional: define R16_TF_PERF_CNT_EN to add stall_cnt[31:0], counting RUN cycles without an input group.
module r16_tf_mul_ctrl
  import r16_tf_pkg::*;
#(
  parameter int GROUP_NUM = R16_GROUP_NUM,
  parameter int ADDR_W    = R16_ADDR_W,
  parameter int MUL_LAT   = R16_MUL_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        stage_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] tf_addr,
  output logic              tf_bypass,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef R16_TF_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);
  r16_state_e        state;
  logic [ADDR_W-1:0] grp_cnt;
  logic [1:0]        stage;
  logic              accept;
  logic              last_grp;
  logic              pipe_busy;
  logic [1:0]        pipe_q;
  assign in_ready  = state == RUN;
  assign accept    = in_valid & in_ready;
  assign last_grp  = grp_cnt == ADDR_W'(GROUP_NUM - 1);
  assign busy      = state != IDLE;
  assign done      = (state == DRAIN) & ~pipe_busy;
  assign out_valid = pipe_q[0];
  assign out_last  = pipe_q[1];
  assign tf_bypass = stage == 2'd3;
  // Each stage keeps the low 4*(3-stage) bits of the group index and moves them up by 4*stage.
  always_comb
    tf_addr = stage == 2'd0 ? grp_cnt & ADDR_W'(32'hFFF) :
              stage == 2'd1 ? (grp_cnt & ADDR_W'(32'hFF)) << R16_RADIX_LOG2 :
              stage == 2'd2 ? (grp_cnt & ADDR_W'(32'hF)) << (2 * R16_RADIX_LOG2) : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      grp_cnt <= '0;
      stage   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          grp_cnt <= '0;
          stage   <= stage_sel;
        end
        RUN: if (accept) begin
          grp_cnt <= grp_cnt + ADDR_W'(1);
          if (last_grp) state <= DRAIN;
        end
        DRAIN: if (!pipe_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  r16_ctrl_delay_line #(.WIDTH(2), .DEPTH(MUL_LAT)) u_dly (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       ({accept & last_grp, accept}),
    .dout      (pipe_q),
    .valid_any (pipe_busy)
  );
`ifdef R16_TF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt <= '0;
    else if (state == IDLE && start) stall_cnt <= '0;
    else if (state == RUN && !in_valid) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_r16_tf_mul_ctrl.sv
// tb_r16_tf_mul_ctrl: directed bench with an event-schedule model of the twiddle-multiply sequencer
module tb_r16_tf_mul_ctrl;
  localparam int N   = 16;
  localparam int LAT = 3;
  localparam int HZ  = 4096;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [1:0] stage_sel = 2'd0;
  logic in_ready, tf_bypass, out_valid, out_last, busy, done;
  logic [11:0] tf_addr;
  logic b_rst_n = 1'b0, b_start = 1'b0, b_valid = 1'b0;
  logic [1:0] b_stage = 2'd0;
  logic b_in_ready, b_tf_bypass, b_out_valid, b_out_last, b_busy, b_done;
  logic [11:0] b_tf_addr;
`ifdef R16_TF_PERF_CNT_EN
  logic [31:0] stall_cnt, b_stall_cnt;
`endif
  r16_tf_mul_ctrl #(.GROUP_NUM(N), .ADDR_W(12), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stage_sel(stage_sel), .in_valid(in_valid),
    .in_ready(in_ready), .tf_addr(tf_addr), .tf_bypass(tf_bypass), .out_valid(out_valid),
    .out_last(out_last), .busy(busy), .done(done)
`ifdef R16_TF_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  r16_tf_mul_ctrl #(.GROUP_NUM(HZ), .ADDR_W(12), .MUL_LAT(LAT)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .start(b_start), .stage_sel(b_stage), .in_valid(b_valid),
    .in_ready(b_in_ready), .tf_addr(b_tf_addr), .tf_bypass(b_tf_bypass), .out_valid(b_out_valid),
    .out_last(b_out_last), .busy(b_busy), .done(b_done)
`ifdef R16_TF_PERF_CNT_EN
    , .stall_cnt(b_stall_cnt)
`endif
  );
  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int exp_addr(input int cnt, input int s);
    return s == 3 ? 0 : ((cnt % (1 << (4 * (3 - s)))) << (4 * s)) % 4096;
  endfunction
  // Model: outputs follow from a schedule of accept events, each landing LAT cycles later.
  bit m_known = 0, m_run = 0, m_busy = 0;
  int m_cnt = 0, m_stage = 0, done_cyc = -1, m_stall = 0;
  bit ev [4096];
  bit el [4096];
  always @(negedge clk) begin
    bit was_busy;
    if (m_known) begin
      chk("in_ready", in_ready, m_run);
      chk("busy", busy, m_busy);
      chk("out_valid", out_valid, ev[cyc]);
      chk("out_last", out_last, el[cyc]);
      chk("done", done, cyc == done_cyc);
      if (m_run && in_valid) begin
        chk("tf_addr", tf_addr, exp_addr(m_cnt, m_stage));
        chk("tf_bypass", tf_bypass, m_stage == 3);
      end
`ifdef R16_TF_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
`endif
    end
    if (!rst_n) begin
      m_known = 1; m_run = 0; m_busy = 0; m_cnt = 0; m_stage = 0; done_cyc = -1; m_stall = 0;
      for (int i = cyc + 1; i < 4096; i++) begin ev[i] = 0; el[i] = 0; end
    end else begin
      was_busy = m_busy;
      if (cyc == done_cyc) m_busy = 0;
      if (!was_busy && start) begin
        m_run = 1; m_busy = 1; m_cnt = 0; m_stage = stage_sel; m_stall = 0;
      end else if (m_run) begin
        if (!in_valid) m_stall++;
        else begin
          ev[cyc + LAT] = 1;
          if (m_cnt == N - 1) begin
            el[cyc + LAT] = 1; m_run = 0; done_cyc = cyc + LAT + 1;
          end
          m_cnt++;
        end
      end
    end
  end
  initial begin
    bit done_seen;
    int nvalid;
    logic [11:0] big_exp [4];
    big_exp[0] = 12'h123; big_exp[1] = 12'h230; big_exp[2] = 12'h300; big_exp[3] = 12'h000;
    // reset held with start asserted
    rst_n = 0; start = 1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_tf_addr", tf_addr, 0);
    chk("rst_tf_bypass", tf_bypass, 0);
    tick();
    rst_n = 1; start = 0;
    tick();
    // stage 0, continuous input
    stage_sel = 0; in_valid = 1;
    for (int k = 0; k < 23; k++) begin
      start = (k == 0);
      @(negedge clk);
      chk("s0_in_ready", in_ready, k >= 1 && k <= 16);
      if (k >= 1 && k <= 16) chk("s0_tf_addr", tf_addr, k - 1);
      chk("s0_out_valid", out_valid, k >= 4 && k <= 19);
      chk("s0_out_last", out_last, k == 19);
      chk("s0_done", done, k == 20);
      chk("s0_busy", busy, k >= 1 && k <= 20);
      tick();
    end
    // stage 1 with bubbles; start pulsed in RUN and DRAIN, stage_sel changed mid-pass
    done_seen = 0; nvalid = 0;
    for (int k = 0; k < 150 && !done_seen; k++) begin
      start = (k == 0) || (k == 5) || (m_busy && !m_run);
      stage_sel = (k == 0) ? 2'd1 : 2'd2;
      in_valid = (k > 0) && (((k - 1) % 4 == 0) || ((k - 1) % 4 == 3));
      @(negedge clk);
      if (out_valid === 1'b1) nvalid++;
      if (done === 1'b1) done_seen = 1;
      if (k >= 4 && k <= 7) chk("bubble_pattern", out_valid, k == 4 || k == 7);
      tick();
    end
    start = 0;
    chk("bubble_done_seen", done_seen, 1);
    chk("bubble_valid_count", nvalid, N);
    tick();
    // stage 3 bypass pass
    stage_sel = 3; in_valid = 1; done_seen = 0;
    for (int k = 0; k < 60 && !done_seen; k++) begin
      start = (k == 0);
      @(negedge clk);
      if (k == 1) begin
        chk("s3_tf_addr", tf_addr, 0);
        chk("s3_tf_bypass", tf_bypass, 1);
      end
      if (done === 1'b1) done_seen = 1;
      tick();
    end
    chk("s3_done_seen", done_seen, 1);
    // stage 2 with five stalled RUN cycles
    stage_sel = 2; done_seen = 0;
    for (int k = 0; k < 60 && !done_seen; k++) begin
      start = (k == 0);
      in_valid = (k >= 6);
      @(negedge clk);
`ifdef R16_TF_PERF_CNT_EN
      if (k == 6) chk("stall_cnt_5", stall_cnt, 5);
`endif
      if (done === 1'b1) done_seen = 1;
      tick();
    end
    chk("stall_pass_done_seen", done_seen, 1);
`ifdef R16_TF_PERF_CNT_EN
    chk("stall_cnt_hold", stall_cnt, 5);
`endif
    // reset mid-pass at grp_cnt 7
    stage_sel = 2; in_valid = 1;
    for (int k = 0; k < 22; k++) begin
      start = (k == 0);
      rst_n = (k != 8);
      @(negedge clk);
      if (k == 8) chk("mid_tf_addr", tf_addr, 12'h700);
      if (k >= 9) begin
        chk("mid_busy", busy, 0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_done", done, 0);
        chk("mid_in_ready", in_ready, 0);
      end
      tick();
    end
    in_valid = 0; start = 0;
    // full-size instance: address mapping at group 0x123 for every stage
    for (int s = 0; s < 4; s++) begin
      b_rst_n = 1; b_stage = 2'(s); b_start = 1;
      tick();
      b_start = 0; b_valid = 1;
      repeat (12'h123) tick();
      @(negedge clk);
      chk("big_tf_addr", b_tf_addr, big_exp[s]);
      chk("big_tf_bypass", b_tf_bypass, s == 3);
      chk("big_in_ready", b_in_ready, 1);
      chk("big_no_out_last", b_out_last, 0);
      tick();
      b_rst_n = 0; b_valid = 0;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
